strobe_writer: RTL and testbench

STROBE_WRITER -- requirements
Module: strobe_writer

---
 rtl/strobe_writer.sv | 154 +++++++++++++++
 tb/tb_strobe_writer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/strobe_writer.sv
// Serial strobe writer: shifts a word out LSB first, framing every bit with
// setup / strobe / hold phases. Define STROBE_WRITER_PARITY_EN to append an even-parity bit.
module strobe_writer #(
   parameter int DATA_W     = 8,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 1,
   parameter int HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              data_out,
   output logic              enable_out,
   output logic              busy
);

`ifdef STROBE_WRITER_PARITY_EN
   localparam int FRAME_W = DATA_W + 1;
`else
   localparam int FRAME_W = DATA_W;
`endif
   localparam int BIT_W = $clog2(FRAME_W);

   localparam logic [3:0]       SETUP_LAST  = 4'(SETUP_CYC - 1);
   localparam logic [3:0]       STROBE_LAST = 4'(STROBE_CYC - 1);
   localparam logic [3:0]       HOLD_LAST   = 4'(HOLD_CYC - 1);
   localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FRAME_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         phaseCnt_q, phaseCnt_d;
   logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
   logic [FRAME_W-1:0] shiftReg_q, shiftReg_d;
   logic               dataOut_q, dataOut_d;
   logic               enable_q, enable_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic [FRAME_W-1:0] loadWord;

`ifdef STROBE_WRITER_PARITY_EN
   assign loadWord = {^tx_data, tx_data};
`else
   assign loadWord = tx_data;
`endif

   // Data only moves on entry to SETUP and the strobe only moves on entry to
   // STROBE/HOLD, so the two lines can never toggle on the same edge.
   always_comb begin
      state_d    = state_q;
      phaseCnt_d = phaseCnt_q;
      bitCnt_d   = bitCnt_q;
      shiftReg_d = shiftReg_q;
      dataOut_d  = dataOut_q;
      enable_d   = enable_q;
      ready_d    = ready_q;
      busy_d     = busy_q;

      case (state_q)
         IDLE: begin
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            enable_d = 1'b0;
            if (tx_valid && ready_q) begin
               state_d    = SETUP;
               ready_d    = 1'b0;
               busy_d     = 1'b1;
               shiftReg_d = loadWord;
               dataOut_d  = loadWord[0];
               phaseCnt_d = 4'd0;
               bitCnt_d   = '0;
            end
         end

         SETUP: begin
            if (phaseCnt_q == SETUP_LAST) begin
               state_d    = STROBE;
               phaseCnt_d = 4'd0;
               enable_d   = 1'b1;
            end else begin
               phaseCnt_d = phaseCnt_q + 4'd1;
            end
         end

         STROBE: begin
            if (phaseCnt_q == STROBE_LAST) begin
               state_d    = HOLD;
               phaseCnt_d = 4'd0;
               enable_d   = 1'b0;
            end else begin
               phaseCnt_d = phaseCnt_q + 4'd1;
            end
         end

         HOLD: begin
            if (phaseCnt_q == HOLD_LAST) begin
               phaseCnt_d = 4'd0;
               if (bitCnt_q == LAST_BIT) begin
                  state_d = IDLE;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d    = SETUP;
                  bitCnt_d   = bitCnt_q + BIT_W'(1);
                  shiftReg_d = shiftReg_q >> 1;
                  dataOut_d  = shiftReg_q[1];
               end
            end else begin
               phaseCnt_d = phaseCnt_q + 4'd1;
            end
         end

         default: begin
            state_d  = IDLE;
            enable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         phaseCnt_q <= 4'd0;
         bitCnt_q   <= '0;
         shiftReg_q <= '0;
         dataOut_q  <= 1'b0;
         enable_q   <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phaseCnt_q <= phaseCnt_d;
         bitCnt_q   <= bitCnt_d;
         shiftReg_q <= shiftReg_d;
         dataOut_q  <= dataOut_d;
         enable_q   <= enable_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_ready   = ready_q;
   assign data_out   = dataOut_q;
   assign enable_out = enable_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_strobe_writer.sv
// Randomized bench for strobe_writer: two instances (default timing and 2/3/1 timing)
// checked cycle by cycle against a waveform model built from the frame rules.
module tb_strobe_writer;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] txDataA = '0, txDataB = '0;
   logic          txValidA = 1'b0, txValidB = 1'b0;
   logic          readyA, dataA, enA, busyA;
   logic          readyB, dataB, enB, busyB;

   int testsRun = 0;
   int testsFailed = 0;
   logic lastBit [2];

   strobe_writer #(.DATA_W(DW), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dutA (
      .clk(clk), .rst_n(rst_n), .tx_data(txDataA), .tx_valid(txValidA),
      .tx_ready(readyA), .data_out(dataA), .enable_out(enA), .busy(busyA)
   );

   strobe_writer #(.DATA_W(DW), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)) dutB (
      .clk(clk), .rst_n(rst_n), .tx_data(txDataB), .tx_valid(txValidB),
      .tx_ready(readyB), .data_out(dataB), .enable_out(enB), .busy(busyB)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Packed view {busy, tx_ready, data_out, enable_out} of one instance
   function automatic logic [3:0] outs(input int sel);
      return (sel != 0) ? {busyB, readyB, dataB, enB} : {busyA, readyA, dataA, enA};
   endfunction

   task automatic applyStimulus(input int sel, input logic v, input logic [DW-1:0] d);
      if (sel == 0) begin
         txValidA = v;
         txDataA  = d;
      end else begin
         txValidB = v;
         txDataB  = d;
      end
   endtask

   // Sends one word and checks every frame cycle; called at a negedge in IDLE
   task automatic sendFrame(input int sel, input logic [DW-1:0] word, input bit keepValid,
                            input bit chain, input logic [DW-1:0] nextWord);
      int setC, strC, holdC, t, nb, frameCyc, strobes, ph;
      logic [32:0] fb;
      logic [3:0] o;
      logic pd, pe, expD, expE;
      setC = (sel != 0) ? 2 : 1;
      strC = (sel != 0) ? 3 : 1;
      holdC = 1;
      t = setC + strC + holdC;
      fb = 33'(word);
      nb = DW;
`ifdef STROBE_WRITER_PARITY_EN
      fb[DW] = ^word;
      nb = DW + 1;
`endif
      frameCyc = nb * t;
      o = outs(sel);
      checkOutput("readyBeforeAccept", 32'(o[2]), 32'd1);
      pd = o[1];
      pe = o[0];
      strobes = 0;
      applyStimulus(sel, 1'b1, word);
      @(negedge clk);
      for (int k = 0; k < frameCyc; k++) begin
         o = outs(sel);
         ph = k % t;
         expD = fb[k / t];
         expE = (ph >= setC) && (ph < setC + strC);
         checkOutput("busy", 32'(o[3]), 32'd1);
         checkOutput("txReadyInFrame", 32'(o[2]), 32'd0);
         checkOutput("dataOut", 32'(o[1]), 32'(expD));
         checkOutput("enableOut", 32'(o[0]), 32'(expE));
         checkOutput("noSimulChange", 32'((o[1] != pd) && (o[0] != pe)), 32'd0);
         if (o[0] && !pe) strobes++;
         pd = o[1];
         pe = o[0];
         if (keepValid)
            applyStimulus(sel, 1'b1, chain ? nextWord : DW'($urandom));
         else
            applyStimulus(sel, 1'b0, DW'($urandom));
         @(negedge clk);
      end
      o = outs(sel);
      checkOutput("strobeCount", 32'(strobes), 32'(nb));
      checkOutput("idleBusy", 32'(o[3]), 32'd0);
      checkOutput("idleReady", 32'(o[2]), 32'd1);
      checkOutput("idleData", 32'(o[1]), 32'(fb[nb-1]));
      checkOutput("idleEnable", 32'(o[0]), 32'd0);
      checkOutput("noSimulChangeIdle", 32'((o[1] != pd) && (o[0] != pe)), 32'd0);
      lastBit[sel] = fb[nb-1];
      if (chain)
         applyStimulus(sel, 1'b1, nextWord);
      else
         applyStimulus(sel, 1'b0, DW'($urandom));
   endtask

   task automatic idleCycles(input int sel, input int n);
      logic [3:0] o;
      for (int i = 0; i < n; i++) begin
         o = outs(sel);
         checkOutput("gapBusy", 32'(o[3]), 32'd0);
         checkOutput("gapReady", 32'(o[2]), 32'd1);
         checkOutput("gapData", 32'(o[1]), 32'(lastBit[sel]));
         checkOutput("gapEnable", 32'(o[0]), 32'd0);
         applyStimulus(sel, 1'b0, DW'($urandom));
         @(negedge clk);
      end
   endtask

   initial begin
      logic [DW-1:0] w;
      int sel;
      lastBit[0] = 1'b0;
      lastBit[1] = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++)
         checkOutput("resetState", 32'(outs(s)), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("readyAfterResetA", 32'(readyA), 32'd1);
      checkOutput("readyAfterResetB", 32'(readyB), 32'd1);

      sendFrame(0, 8'hA5, 1'b0, 1'b0, 8'h00);
      idleCycles(0, 2);
      sendFrame(1, 8'h01, 1'b0, 1'b0, 8'h00);
      idleCycles(1, 1);

      // Back-to-back words with tx_valid never dropping
      sendFrame(0, 8'h3C, 1'b1, 1'b1, 8'hC3);
      sendFrame(0, 8'hC3, 1'b0, 1'b0, 8'h00);

      // Mid-frame tx_data churn with tx_valid high
      sendFrame(0, 8'h5A, 1'b1, 1'b0, 8'h00);
      idleCycles(0, 1);

      sendFrame(0, 8'h07, 1'b0, 1'b0, 8'h00);
      sendFrame(0, 8'h03, 1'b0, 1'b0, 8'h00);

      // Reset during STROBE of bit 3
      applyStimulus(0, 1'b1, 8'hFF);
      @(negedge clk);
      applyStimulus(0, 1'b0, 8'h00);
      repeat (10) @(negedge clk);
      checkOutput("strobeBeforeReset", 32'(enA), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("resetEnable", 32'(enA), 32'd0);
      checkOutput("resetBusy", 32'(busyA), 32'd0);
      checkOutput("resetReady", 32'(readyA), 32'd0);
      checkOutput("resetData", 32'(dataA), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("readyAfterMidReset", 32'(readyA), 32'd1);
      lastBit[0] = 1'b0;
      lastBit[1] = 1'b0;
      sendFrame(0, 8'h96, 1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 24; i++) begin
         sel = int'($urandom_range(0, 1));
         w = DW'($urandom);
         sendFrame(sel, w, bit'($urandom_range(0, 1)), 1'b0, 8'h00);
         idleCycles(sel, int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
